// File: rtl/ps2_scan_decoder_pkg.sv
// Shared scan-code constants, FSM states and event record for the PS/2 decoder.
package ps2_scan_decoder_pkg;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_E1     = 8'hE1;
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;
  localparam logic [7:0] CODE_ERR0   = 8'h00;
  localparam logic [7:0] CODE_ERR1   = 8'hFF;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_FAKE   = 8'h7C;

  // Pause sends E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // Keyboard status/ack bytes that never form a key event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == CODE_BAT_OK) || (b == CODE_ACK) || (b == CODE_RESEND) ||
           (b == CODE_ECHO) || (b == CODE_ERR0) || (b == CODE_ERR1);
  endfunction

  // Shift bytes that E0 sequences insert around navigation keys.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == CODE_LSHIFT) || (b == CODE_FAKE);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_event_fifo.sv
// Small show-ahead FIFO holding decoded key events.
module ps2_event_fifo
  import ps2_scan_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are masked by empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Scan-code set 2 decoder: prefix FSM, timeout, event queue and modifier levels.
module ps2_scan_decoder
  import ps2_scan_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  input  logic       key_rd,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [TW-1:0] tmo_q;
  logic       ev_valid_q, ev_valid_d;
  key_event_t ev_q, ev_d;
  key_event_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop_ok;
  logic       lshift, rshift, lctrl, rctrl;

  assign pop_ok     = key_rd & key_valid;
  assign key_valid  = ~fifo_empty;
  assign key_code   = head.code;
  assign key_ext    = head.ext;
  assign key_brk    = head.brk;
  assign shift_held = lshift | rshift;
  assign ctrl_held  = lctrl | rctrl;

  // Next-state and event decode; only received bytes or the timeout move the FSM.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    ev_valid_d = 1'b0;
    ev_d       = '0;
    if (rx_done_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == CODE_E0)      state_d = ST_EXT;
          else if (rx_byte == CODE_F0) state_d = ST_BRK;
          else if (rx_byte == CODE_E1) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_TAIL;
          end else if (!is_ignored(rx_byte)) begin
            ev_valid_d = 1'b1;
            ev_d       = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
          end
        end
        ST_EXT: begin
          // A repeated E0 after a fake shift keeps the extended prefix pending.
          if (rx_byte == CODE_F0) state_d = ST_EXTBRK;
          else if (!is_fake_shift(rx_byte) && rx_byte != CODE_E0) begin
            state_d    = ST_IDLE;
            ev_valid_d = 1'b1;
            ev_d       = '{ext: 1'b1, brk: 1'b0, code: rx_byte};
          end
        end
        ST_BRK: begin
          state_d    = ST_IDLE;
          ev_valid_d = 1'b1;
          ev_d       = '{ext: 1'b0, brk: 1'b1, code: rx_byte};
        end
        ST_EXTBRK: begin
          state_d = ST_IDLE;
          if (!is_fake_shift(rx_byte)) begin
            ev_valid_d = 1'b1;
            ev_d       = '{ext: 1'b1, brk: 1'b1, code: rx_byte};
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end
  end

  // FSM, skip counter and the one-cycle event staging register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_q       <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      ev_valid_q <= ev_valid_d;
      ev_q       <= ev_d;
    end
  end

  // Inter-byte timeout; only runs while a prefix is pending.
  always_ff @(posedge clk) begin
    if (!reset || rx_done_tick || state_q == ST_IDLE) tmo_q <= '0;
    else                                              tmo_q <= tmo_q + 1'b1;
  end

  // Modifier levels follow every emitted event, even one the FIFO drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      lctrl  <= 1'b0;
      rctrl  <= 1'b0;
    end else if (ev_valid_q) begin
      if (!ev_q.ext && ev_q.code == CODE_LSHIFT) lshift <= ~ev_q.brk;
      if (!ev_q.ext && ev_q.code == CODE_RSHIFT) rshift <= ~ev_q.brk;
      if (!ev_q.ext && ev_q.code == CODE_CTRL)   lctrl  <= ~ev_q.brk;
      if (ev_q.ext && ev_q.code == CODE_CTRL)    rctrl  <= ~ev_q.brk;
    end
  end

  // Sticky record of any event lost to a full queue.
  always_ff @(posedge clk) begin
    if (!reset)                                     overflow <= 1'b0;
    else if (ev_valid_q && fifo_full && !pop_ok)    overflow <= 1'b1;
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_valid_q),
    .pop   (pop_ok),
    .din   (ev_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench: directed cycle table, hand sequences, randomized run vs. a byte-level model.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       key_rd = 1'b0;
  logic       key_valid, key_ext, key_brk, shift_held, ctrl_held, overflow;
  logic [7:0] key_code;

  int unsigned vec = 0;
  int unsigned mis = 0;

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_byte      (rx_byte),
    .key_rd       (key_rd),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_brk      (key_brk),
    .shift_held   (shift_held),
    .ctrl_held    (ctrl_held),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte-level, flag based) ----------------
  logic [9:0]  mq [$];
  logic        m_ext, m_brk, m_pv, m_ovf, m_lsh, m_rsh, m_lc, m_rc;
  logic [9:0]  m_pev;
  int unsigned m_skip, m_gap;

  task automatic m_clear_prefix();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic m_emit(input logic x, input logic k, input logic [7:0] c);
    m_pv = 1; m_pev = {x, k, c};
  endtask

  task automatic m_decode(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (m_ext && m_brk) begin
      m_clear_prefix();
      if (b != 8'h12 && b != 8'h7C) m_emit(1, 1, b);
    end else if (m_brk) begin
      m_clear_prefix(); m_emit(0, 1, b);
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'h12 && b != 8'h7C && b != 8'hE0) begin
        m_clear_prefix(); m_emit(1, 0, b);
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: m_skip = 7;
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
        default: m_emit(0, 0, b);
      endcase
    end
  endtask

  task automatic model_edge(input logic rs, input logic tk, input logic [7:0] b, input logic rd);
    logic [9:0] t;
    if (!rs) begin
      mq.delete(); m_clear_prefix(); m_gap = 0; m_pv = 0; m_ovf = 0;
      m_lsh = 0; m_rsh = 0; m_lc = 0; m_rc = 0;
      return;
    end
    if (rd && mq.size() > 0) t = mq.pop_front();
    if (m_pv) begin
      if (!m_pev[9] && m_pev[7:0] == 8'h12) m_lsh = !m_pev[8];
      if (!m_pev[9] && m_pev[7:0] == 8'h59) m_rsh = !m_pev[8];
      if (!m_pev[9] && m_pev[7:0] == 8'h14) m_lc  = !m_pev[8];
      if ( m_pev[9] && m_pev[7:0] == 8'h14) m_rc  = !m_pev[8];
      if (mq.size() < DEPTH) mq.push_back(m_pev);
      else m_ovf = 1;
      m_pv = 0;
    end
    if (tk) begin
      m_gap = 0;
      m_decode(b);
    end else if (m_ext || m_brk || m_skip > 0) begin
      m_gap++;
      if (m_gap >= TMO) m_clear_prefix();
    end
  endtask

  function automatic logic [13:0] ev(input logic v, input logic x, input logic k,
                                     input logic [7:0] c, input logic sh, input logic ct,
                                     input logic ov);
    return {v, x, k, c, sh, ct, ov};
  endfunction

  function automatic logic [13:0] model_vec();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    return {mq.size() > 0, h, m_lsh | m_rsh, m_lc | m_rc, m_ovf};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {key_valid, key_ext, key_brk, key_code, shift_held, ctrl_held, overflow};
  endfunction

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    vec++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s: got {v,ext,brk,code,sh,ct,ovf}=%b_%b_%b_%h_%b_%b_%b required %b_%b_%b_%h_%b_%b_%b",
               name, got[13], got[12], got[11], got[10:3], got[2], got[1], got[0],
               exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One clock: drive, advance model, then sample 1 time unit after the edge.
  task automatic cyc(input logic rs, input logic tk, input logic [7:0] b, input logic rd);
    reset = rs; rx_done_tick = tk; rx_byte = b; key_rd = rd;
    model_edge(rs, tk, b, rd);
    @(posedge clk);
    #1;
    reset = 1'b1; rx_done_tick = 1'b0; key_rd = 1'b0;
  endtask

  // ---------------- directed per-cycle table ----------------
  typedef struct {
    logic       rs;
    logic       tk;
    logic [7:0] b;
    logic       rd;
    logic [13:0] exp;
  } row_t;

  row_t tbl [$];

  task automatic add(input logic rs, input logic tk, input logic [7:0] b, input logic rd,
                     input logic v, input logic x, input logic k, input logic [7:0] c,
                     input logic sh, input logic ct, input logic ov);
    row_t r;
    r.rs = rs; r.tk = tk; r.b = b; r.rd = rd; r.exp = ev(v, x, k, c, sh, ct, ov);
    tbl.push_back(r);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 15))
      0, 1:    return 8'hE0;
      2, 3:    return 8'hF0;
      4:       return 8'hE1;
      5:       return 8'h12;
      6:       return 8'h59;
      7:       return 8'h14;
      8:       return 8'h7C;
      9:       return 8'hAA;
      10:      return 8'h00;
      11:      return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    // reset and idle
    add(0,0,8'h00,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 0,0,0,8'h00,0,0,0);
    // plain make, latency one clock, then pop
    add(1,1,8'h1C,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,0,0,8'h1C,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    // break, back-to-back bytes
    add(1,1,8'hF0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h1C,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,0,1,8'h1C,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    // extended make
    add(1,1,8'hE0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h75,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,1,0,8'h75,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    // extended break
    add(1,1,8'hE0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'hF0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h75,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,1,1,8'h75,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    // left shift press and release
    add(1,1,8'h12,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,0,0,8'h12,1,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,1,0,0);
    add(1,1,8'hF0,0, 0,0,0,8'h00,1,0,0);
    add(1,1,8'h12,0, 0,0,0,8'h00,1,0,0);
    add(1,0,8'h00,0, 1,0,1,8'h12,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    // right ctrl press
    add(1,1,8'hE0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h14,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,1,0,8'h14,0,1,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,1,0);
    // fake shift inside extended sequence
    add(1,1,8'hE0,0, 0,0,0,8'h00,0,1,0);
    add(1,1,8'h12,0, 0,0,0,8'h00,0,1,0);
    add(1,1,8'hE0,0, 0,0,0,8'h00,0,1,0);
    add(1,1,8'h4A,0, 0,0,0,8'h00,0,1,0);
    add(1,0,8'h00,0, 1,1,0,8'h4A,0,1,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,1,0);
    add(1,0,8'h00,0, 0,0,0,8'h00,0,1,0);
    // right ctrl release
    add(1,1,8'hE0,0, 0,0,0,8'h00,0,1,0);
    add(1,1,8'hF0,0, 0,0,0,8'h00,0,1,0);
    add(1,1,8'h14,0, 0,0,0,8'h00,0,1,0);
    add(1,0,8'h00,0, 1,1,1,8'h14,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    // pause sequence swallowed, following make decoded
    add(1,1,8'hE1,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h14,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h77,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'hE1,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'hF0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h14,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'hF0,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h77,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h1C,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 1,0,0,8'h1C,0,0,0);
    add(1,0,8'h00,1, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 0,0,0,8'h00,0,0,0);
    // ignored status bytes; pop on empty is harmless
    add(1,1,8'hAA,0, 0,0,0,8'h00,0,0,0);
    add(1,1,8'h00,1, 0,0,0,8'h00,0,0,0);
    add(1,1,8'hFF,0, 0,0,0,8'h00,0,0,0);
    add(1,0,8'h00,0, 0,0,0,8'h00,0,0,0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rs, tbl[i].tk, tbl[i].b, tbl[i].rd);
      chk($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // timeout: a gap of TIMEOUT idle cycles abandons the E0 prefix
    cyc(1, 1, 8'hE0, 0);
    for (int unsigned i = 0; i < TMO; i++) cyc(1, 0, 8'h00, 0);
    cyc(1, 1, 8'h1C, 0);
    cyc(1, 0, 8'h00, 0);
    chk("timeout_abort", dut_vec(), ev(1,0,0,8'h1C,0,0,0));
    cyc(1, 0, 8'h00, 1);
    // one cycle short of the abort the prefix still applies
    cyc(1, 1, 8'hE0, 0);
    for (int unsigned i = 0; i + 1 < TMO; i++) cyc(1, 0, 8'h00, 0);
    cyc(1, 1, 8'h75, 0);
    cyc(1, 0, 8'h00, 0);
    chk("timeout_edge", dut_vec(), ev(1,1,0,8'h75,0,0,0));
    cyc(1, 0, 8'h00, 1);

    // fill to depth, then a fifth make is dropped
    cyc(1, 1, 8'h1C, 0);
    cyc(1, 1, 8'h32, 0);
    cyc(1, 1, 8'h21, 0);
    cyc(1, 1, 8'h23, 0);
    cyc(1, 1, 8'h2B, 0);
    chk("full_no_ovf", dut_vec(), ev(1,0,0,8'h1C,0,0,0));
    cyc(1, 0, 8'h00, 0);
    chk("overflow_set", dut_vec(), ev(1,0,0,8'h1C,0,0,1));
    // push and pop together while full
    cyc(1, 1, 8'h34, 0);
    cyc(1, 0, 8'h00, 1);
    chk("push_pop_full", dut_vec(), ev(1,0,0,8'h32,0,0,1));
    cyc(1, 0, 8'h00, 1);
    chk("drain_1", dut_vec(), ev(1,0,0,8'h21,0,0,1));
    cyc(1, 0, 8'h00, 1);
    chk("drain_2", dut_vec(), ev(1,0,0,8'h23,0,0,1));
    cyc(1, 0, 8'h00, 1);
    chk("drain_3", dut_vec(), ev(1,0,0,8'h34,0,0,1));
    cyc(1, 0, 8'h00, 1);
    chk("drain_empty", dut_vec(), ev(0,0,0,8'h00,0,0,1));

    // one-cycle reset clears queue, modifiers and overflow
    cyc(1, 1, 8'h12, 0);
    cyc(1, 1, 8'h1C, 0);
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hE0, 0);
    chk("reset_clear", dut_vec(), ev(0,0,0,8'h00,0,0,0));
    // reset discards a pending prefix
    cyc(1, 1, 8'hE0, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'h75, 0);
    cyc(1, 0, 8'h00, 0);
    chk("reset_mid_prefix", dut_vec(), ev(1,0,0,8'h75,0,0,0));
    cyc(1, 0, 8'h00, 1);

    // randomized traffic against the model
    cyc(0, 0, 8'h00, 0);
    for (int unsigned n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        int unsigned gap;
        gap = $urandom_range(TMO - 3, TMO + 3);
        for (int unsigned g = 0; g < gap; g++) begin
          cyc(1, 0, 8'h00, ($urandom_range(0, 3) == 0));
          chk("random_gap", dut_vec(), model_vec());
        end
      end
      cyc(($urandom_range(0, 799) != 0), ($urandom_range(0, 1) == 1), pick(),
          ($urandom_range(0, 3) == 0));
      chk("random", dut_vec(), model_vec());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
